max7219_scroller_ctrl_multi: RTL and testbench



---
 rtl/max7219_scroller_pkg.sv | 37 +++
 rtl/max7219_scroller_ram.sv | 40 ++++
 rtl/max7219_scroller_ctrl_multi.sv | 248 ++++++++++++++++++++++++
 tb/tb_max7219_scroller_ctrl_multi.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_scroller_pkg.sv
// Shared types and MAX7219 register constants for the scroller controller.
package max7219_scroller_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_RD,
    S_SEND,
    S_TEMPO,
    S_DONE
  } state_t;

  localparam logic [3:0] REG_DECODE     = 4'h9;
  localparam logic [3:0] REG_INTENSITY  = 4'hA;
  localparam logic [3:0] REG_SCAN_LIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN   = 4'hC;
  localparam logic [3:0] REG_TEST       = 4'hF;

  localparam logic [7:0] VAL_NORMAL_OP  = 8'h01;
  localparam logic [7:0] VAL_NO_DECODE  = 8'h00;
  localparam logic [7:0] VAL_SCAN_ALL   = 8'h07;
  localparam logic [7:0] VAL_TEST_OFF   = 8'h00;

  localparam logic [2:0] CFG_LAST = 3'd4;

  // {reg, value} of the idx-th init register, in send order
  function automatic logic [11:0] cfg_word(input logic [2:0] idx, input logic [3:0] intensity);
    case (idx)
      3'd0:    cfg_word = {REG_SHUTDOWN, VAL_NORMAL_OP};
      3'd1:    cfg_word = {REG_DECODE, VAL_NO_DECODE};
      3'd2:    cfg_word = {REG_SCAN_LIMIT, VAL_SCAN_ALL};
      3'd3:    cfg_word = {REG_INTENSITY, 4'h0, intensity};
      default: cfg_word = {REG_TEST, VAL_TEST_OFF};
    endcase
  endfunction

endpackage

// File: rtl/max7219_scroller_ram.sv
// True dual-port synchronous-read RAM: port A host read/write, port B scroller read.
module max7219_scroller_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_me_i,
  input  logic          a_we_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [DW-1:0] a_wdata_i,
  output logic [DW-1:0] a_rdata_o,
  input  logic          b_re_i,
  input  logic [AW-1:0] b_addr_i,
  output logic [DW-1:0] b_rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] a_rdata_q;
  logic [DW-1:0] b_rdata_q;

  always_ff @(posedge clk) begin
    if (a_me_i && a_we_i) mem_q[a_addr_i] <= a_wdata_i;
  end

  // Reads sample the array before this cycle's write lands (read-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_me_i) a_rdata_q <= mem_q[a_addr_i];
      if (b_re_i) b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/max7219_scroller_ctrl_multi.sv
// Scroller controller: initialises a MAX7219 chain and scrolls RAM-held columns across it.
module max7219_scroller_ctrl_multi
  import max7219_scroller_pkg::*;
#(
  parameter int G_MATRIX_NB      = 8,
  parameter int G_RAM_ADDR_WIDTH = 8,
  parameter int G_RAM_DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_me,
  input  logic                        i_we,
  input  logic [G_RAM_ADDR_WIDTH-1:0] i_addr,
  input  logic [G_RAM_DATA_WIDTH-1:0] i_wdata,
  output logic [G_RAM_DATA_WIDTH-1:0] o_rdata,
  input  logic [G_RAM_ADDR_WIDTH-1:0] i_ram_start_ptr,
  input  logic [G_RAM_ADDR_WIDTH-1:0] i_msg_length,
  input  logic                        i_start_scroll,
  input  logic                        i_stop,
  input  logic                        i_dir,
  input  logic                        i_loop,
  input  logic [3:0]                  i_intensity,
  input  logic [31:0]                 i_max_tempo_cnt,
  input  logic                        i_max7219_if_done,
  output logic                        o_max7219_if_start,
  output logic                        o_max7219_if_en_load,
  output logic [15:0]                 o_max7219_if_data,
  output logic                        o_busy,
  output logic                        o_frame_done,
  output logic                        o_scroll_done
);

  localparam int AW = G_RAM_ADDR_WIDTH;
  localparam int MW = (G_MATRIX_NB > 1) ? $clog2(G_MATRIX_NB) : 1;
  localparam int KW = MW + 3;
  localparam int CW = (KW > AW) ? KW : AW;
  localparam logic [MW-1:0] MAT_LAST = MW'(G_MATRIX_NB - 1);
  localparam logic [MW-1:0] MAT_ONE  = MW'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  state_t        state_q, state_d;
  logic          pend_q, pend_d;
  logic [MW-1:0] mat_q, mat_d;
  logic [2:0]    dig_q, dig_d;
  logic [2:0]    cfg_idx_q, cfg_idx_d;
  logic [AW-1:0] pos_q, pos_d;
  logic          moved_q, moved_d;
  logic          stop_q, stop_d;
  logic [31:0]   tcnt_q, tcnt_d;
  logic          frame_done_q, frame_done_d;
  logic [AW-1:0] start_ptr_q, start_ptr_d;
  logic [AW-1:0] len_q, len_d;
  logic          dir_q, dir_d;
  logic          loop_q, loop_d;
  logic [3:0]    intensity_q, intensity_d;
  logic [31:0]   tempo_max_q, tempo_max_d;

  logic [KW-1:0] col_k;
  logic          zero_col;
  logic [AW:0]   col_sum;
  logic          col_wrap;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] pos_next;
  logic [G_RAM_DATA_WIDTH-1:0] b_rdata;

  // Column index k = m*8 + (d-1); dig_q holds d-1.
  assign col_k    = {mat_q, dig_q};
  assign zero_col = CW'(col_k) >= CW'(len_q);
  assign col_sum  = {1'b0, pos_q} + {1'b0, AW'(col_k)};
  assign col_wrap = col_sum >= {1'b0, len_q};
  assign rd_addr  = start_ptr_q + AW'(col_wrap ? col_sum - {1'b0, len_q} : col_sum);
  assign pos_next = dir_q ? ((pos_q == '0) ? len_q - ADDR_ONE : pos_q - ADDR_ONE)
                          : ((pos_q == len_q - ADDR_ONE) ? '0 : pos_q + ADDR_ONE);

  max7219_scroller_ram #(
    .AW(G_RAM_ADDR_WIDTH),
    .DW(G_RAM_DATA_WIDTH)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .a_me_i   (i_me),
    .a_we_i   (i_we),
    .a_addr_i (i_addr),
    .a_wdata_i(i_wdata),
    .a_rdata_o(o_rdata),
    .b_re_i   (state_q == S_RD),
    .b_addr_i (rd_addr),
    .b_rdata_o(b_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pend_q       <= 1'b0;
      mat_q        <= '0;
      dig_q        <= '0;
      cfg_idx_q    <= '0;
      pos_q        <= '0;
      moved_q      <= 1'b0;
      stop_q       <= 1'b0;
      tcnt_q       <= '0;
      frame_done_q <= 1'b0;
      start_ptr_q  <= '0;
      len_q        <= '0;
      dir_q        <= 1'b0;
      loop_q       <= 1'b0;
      intensity_q  <= '0;
      tempo_max_q  <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      mat_q        <= mat_d;
      dig_q        <= dig_d;
      cfg_idx_q    <= cfg_idx_d;
      pos_q        <= pos_d;
      moved_q      <= moved_d;
      stop_q       <= stop_d;
      tcnt_q       <= tcnt_d;
      frame_done_q <= frame_done_d;
      start_ptr_q  <= start_ptr_d;
      len_q        <= len_d;
      dir_q        <= dir_d;
      loop_q       <= loop_d;
      intensity_q  <= intensity_d;
      tempo_max_q  <= tempo_max_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    mat_d        = mat_q;
    dig_d        = dig_q;
    cfg_idx_d    = cfg_idx_q;
    pos_d        = pos_q;
    moved_d      = moved_q;
    stop_d       = stop_q;
    tcnt_d       = tcnt_q;
    frame_done_d = 1'b0;
    start_ptr_d  = start_ptr_q;
    len_d        = len_q;
    dir_d        = dir_q;
    loop_d       = loop_q;
    intensity_d  = intensity_q;
    tempo_max_d  = tempo_max_q;
    if (state_q != S_IDLE && i_stop) stop_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (i_start_scroll && i_msg_length != '0) begin
          state_d     = S_CFG;
          pend_d      = 1'b0;
          mat_d       = MAT_LAST;
          dig_d       = '0;
          cfg_idx_d   = '0;
          pos_d       = '0;
          moved_d     = 1'b0;
          stop_d      = 1'b0;
          start_ptr_d = i_ram_start_ptr;
          len_d       = i_msg_length;
          dir_d       = i_dir;
          loop_d      = i_loop;
          intensity_d = i_intensity;
          tempo_max_d = i_max_tempo_cnt;
        end
      end
      S_CFG: begin
        if (!pend_q) begin
          pend_d = 1'b1;
        end else if (i_max7219_if_done) begin
          pend_d = 1'b0;
          if (mat_q == '0) begin
            mat_d = MAT_LAST;
            if (cfg_idx_q == CFG_LAST) state_d = S_RD;
            else cfg_idx_d = cfg_idx_q + 3'd1;
          end else begin
            mat_d = mat_q - MAT_ONE;
          end
        end
      end
      S_RD: state_d = S_SEND;
      S_SEND: begin
        if (!pend_q) begin
          pend_d = 1'b1;
        end else if (i_max7219_if_done) begin
          pend_d = 1'b0;
          if (mat_q != '0) begin
            mat_d   = mat_q - MAT_ONE;
            state_d = S_RD;
          end else if (dig_q != 3'd7) begin
            mat_d   = MAT_LAST;
            dig_d   = dig_q + 3'd1;
            state_d = S_RD;
          end else begin
            frame_done_d = 1'b1;
            mat_d        = MAT_LAST;
            dig_d        = '0;
            if (stop_q || i_stop || (!loop_q && moved_q && pos_q == '0)) begin
              state_d = S_DONE;
            end else if (tempo_max_q == '0) begin
              pos_d   = pos_next;
              moved_d = 1'b1;
              state_d = S_RD;
            end else begin
              tcnt_d  = '0;
              state_d = S_TEMPO;
            end
          end
        end
      end
      S_TEMPO: begin
        if (tcnt_q == tempo_max_q - 32'd1) begin
          pos_d   = pos_next;
          moved_d = 1'b1;
          state_d = S_RD;
        end else begin
          tcnt_d = tcnt_q + 32'd1;
        end
      end
      // Two cycles: the first lines scroll_done up one cycle behind frame_done.
      S_DONE: begin
        if (!pend_q) begin
          pend_d = 1'b1;
        end else begin
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy               = state_q != S_IDLE;
    o_max7219_if_start   = (state_q == S_CFG || state_q == S_SEND) && !pend_q;
    o_frame_done         = frame_done_q;
    o_scroll_done        = state_q == S_DONE && pend_q;
    o_max7219_if_data    = '0;
    o_max7219_if_en_load = 1'b0;
    if (state_q == S_CFG) begin
      o_max7219_if_data    = {4'h0, cfg_word(cfg_idx_q, intensity_q)};
      o_max7219_if_en_load = mat_q == '0;
    end else if (state_q == S_SEND) begin
      o_max7219_if_data    = {4'h0, {1'b0, dig_q} + 4'd1, zero_col ? 8'h00 : b_rdata};
      o_max7219_if_en_load = mat_q == '0;
    end
  end

endmodule

// File: tb/tb_max7219_scroller_ctrl_multi.sv
// Directed bench: serializer responder/monitor plus hand-computed word and timing checks.
module tb_max7219_scroller_ctrl_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_me = 1'b0, i_we = 1'b0;
  logic [7:0]  i_addr = '0, i_wdata = '0, o_rdata;
  logic [7:0]  i_ram_start_ptr = '0, i_msg_length = '0;
  logic        i_start_scroll = 1'b0, i_stop = 1'b0, i_dir = 1'b0, i_loop = 1'b0;
  logic [3:0]  i_intensity = '0;
  logic [31:0] i_max_tempo_cnt = '0;
  logic        i_max7219_if_done = 1'b0;
  logic        o_max7219_if_start, o_max7219_if_en_load;
  logic [15:0] o_max7219_if_data;
  logic        o_busy, o_frame_done, o_scroll_done;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int t0;
  logic [7:0] rd;

  logic [15:0] words[$];
  logic        eloads[$];
  int          scyc[$];
  int          fd_cyc[$];
  int          sd_cyc[$];
  logic        sd_busy[$];

  max7219_scroller_ctrl_multi #(
    .G_MATRIX_NB(8),
    .G_RAM_ADDR_WIDTH(8),
    .G_RAM_DATA_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_me(i_me), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .i_ram_start_ptr(i_ram_start_ptr), .i_msg_length(i_msg_length),
    .i_start_scroll(i_start_scroll), .i_stop(i_stop), .i_dir(i_dir), .i_loop(i_loop),
    .i_intensity(i_intensity), .i_max_tempo_cnt(i_max_tempo_cnt),
    .i_max7219_if_done(i_max7219_if_done),
    .o_max7219_if_start(o_max7219_if_start), .o_max7219_if_en_load(o_max7219_if_en_load),
    .o_max7219_if_data(o_max7219_if_data),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_scroll_done(o_scroll_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Serializer model: done two cycles after each start; logs everything it sees.
  always @(negedge clk) begin
    i_max7219_if_done = 1'b0;
    if (resp_cnt != 0) begin
      resp_cnt = resp_cnt - 1;
      if (resp_cnt == 0) i_max7219_if_done = 1'b1;
    end
    if (o_max7219_if_start) begin
      words.push_back(o_max7219_if_data);
      eloads.push_back(o_max7219_if_en_load);
      scyc.push_back(cyc);
      resp_cnt = 2;
    end
    if (o_frame_done) fd_cyc.push_back(cyc);
    if (o_scroll_done) begin
      sd_cyc.push_back(cyc);
      sd_busy.push_back(o_busy);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    i_me = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = d;
    @(negedge clk);
    i_me = 1'b0; i_we = 1'b0;
  endtask

  task automatic host_rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    i_me = 1'b1; i_we = 1'b0; i_addr = a;
    @(negedge clk);
    i_me = 1'b0;
    d = o_rdata;
  endtask

  task automatic start_scroll(input logic [7:0] ptr, input logic [7:0] len, input logic dir,
                              input logic lp, input logic [3:0] inten, input logic [31:0] tempo);
    @(negedge clk);
    words.delete(); eloads.delete(); scyc.delete();
    fd_cyc.delete(); sd_cyc.delete(); sd_busy.delete();
    i_ram_start_ptr = ptr; i_msg_length = len; i_dir = dir; i_loop = lp;
    i_intensity = inten; i_max_tempo_cnt = tempo;
    i_start_scroll = 1'b1;
    t0 = cyc;
    @(negedge clk);
    i_start_scroll = 1'b0;
  endtask

  task automatic wait_sd(input string tag, input int budget);
    int n = 0;
    while (sd_cyc.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, sd_cyc.size(), 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_words(input string tag, input int cnt, input int budget);
    int n = 0;
    while (words.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, words.size() >= cnt, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_outs", {o_busy, o_max7219_if_start, o_max7219_if_en_load, o_frame_done,
                       o_scroll_done, o_max7219_if_data, o_rdata}, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 256; k++) host_wr(8'(k), 8'(k));
    host_rd(8'h05, rd);
    check("host_rd_05", rd, 8'h05);

    // Config sequence and first frame; stop latched during CFG ends after frame 0.
    start_scroll(8'h00, 8'd64, 1'b0, 1'b0, 4'h5, 32'd0);
    check("t1_busy_t1", o_busy, 1);
    check("t1_start_t1", o_max7219_if_start, 1);
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    wait_sd("t1_done", 3000);
    check("t1_first_start_cyc", scyc[0], t0 + 1);
    check("t1_nwords", words.size(), 104);
    check("t1_w0", words[0], 16'h0C01);
    check("t1_w8", words[8], 16'h0900);
    check("t1_w16", words[16], 16'h0B07);
    check("t1_w24", words[24], 16'h0A05);
    check("t1_w32", words[32], 16'h0F00);
    begin
      int nl = 0;
      for (int k = 0; k < 40; k++) nl += int'(eloads[k]);
      check("t1_cfg_loads", nl, 5);
    end
    check("t1_el7", eloads[7], 1);
    check("t1_el38", eloads[38], 0);
    check("t1_w40", words[40], 16'h0138);
    check("t1_w41", words[41], 16'h0130);
    check("t1_el46", eloads[46], 0);
    check("t1_el47", {eloads[47], words[47]}, 17'h10100);
    check("t1_w103", {eloads[103], words[103]}, 17'h10807);
    check("t1_nframes", fd_cyc.size(), 1);

    // One-shot, L=3: L+1 frames, columns beyond L blank.
    start_scroll(8'h00, 8'd3, 1'b0, 1'b0, 4'h1, 32'd0);
    wait_sd("t2_done", 5000);
    check("t2_nframes", fd_cyc.size(), 4);
    check("t2_nwords", words.size(), 296);
    check("t2_f1_k1", words[40 + 64 + 15], 16'h0202);
    check("t2_f1_k3", words[40 + 64 + 31], 16'h0400);
    check("t2_f1_k8", words[40 + 64 + 6], 16'h0100);
    check("t2_f2_k1", words[40 + 128 + 15], 16'h0200);
    check("t2_f2_k2", words[40 + 128 + 23], 16'h0301);
    check("t2_tempo0_gap", scyc[104] - fd_cyc[0], 1);
    check("t2_sd_after_fd", sd_cyc[0] - fd_cyc[3], 1);
    check("t2_busy_at_sd", sd_busy[0], 1);
    check("t2_busy_low", o_busy, 0);

    // Right scroll with RAM pointer wrap past 0xFF.
    host_wr(8'hFE, 8'hA0);
    host_wr(8'hFF, 8'hA1);
    host_wr(8'h00, 8'hA2);
    host_wr(8'h01, 8'hA3);
    start_scroll(8'hFE, 8'd4, 1'b1, 1'b0, 4'h2, 32'd0);
    host_rd(8'hFF, rd);
    check("t3_host_rd_busy", rd, 8'hA1);
    wait_sd("t3_done", 6000);
    check("t3_nframes", fd_cyc.size(), 5);
    check("t3_nwords", words.size(), 360);
    check("t3_f0_k8", words[40 + 6], 16'h0100);
    check("t3_f1_k0", words[40 + 64 + 7], 16'h01A3);
    check("t3_f1_k1", words[40 + 64 + 15], 16'h02A0);
    check("t3_f2_k0", words[40 + 128 + 7], 16'h01A2);
    check("t3_f4_k0", words[40 + 256 + 7], 16'h01A0);

    // Loop mode, stop during the third frame's 10th transfer.
    start_scroll(8'h00, 8'd64, 1'b0, 1'b1, 4'h3, 32'd0);
    wait_words("t4_reach", 178, 3000);
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    wait_sd("t4_done", 3000);
    repeat (20) @(negedge clk);
    check("t4_nwords", words.size(), 232);
    check("t4_nframes", fd_cyc.size(), 3);
    check("t4_sd_after_fd", sd_cyc[0] - fd_cyc[2], 1);
    check("t4_f2_w0", words[168], 16'h013A);
    check("t4_busy_low", o_busy, 0);

    // Tempo of 100 idle cycles between frames.
    start_scroll(8'h10, 8'd2, 1'b0, 1'b0, 4'h4, 32'd100);
    wait_sd("t5_done", 3000);
    check("t5_nframes", fd_cyc.size(), 3);
    check("t5_tempo_gap", scyc[104] - fd_cyc[0], 101);
    check("t5_f1_k0", words[40 + 64 + 7], 16'h0111);
    check("t5_f1_k1", words[40 + 64 + 15], 16'h0210);

    // Reset during CFG, then ignored zero-length start.
    start_scroll(8'h00, 8'd4, 1'b0, 1'b1, 4'h6, 32'd0);
    wait_words("t6_reach", 3, 100);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_outs", {o_busy, o_max7219_if_start, o_max7219_if_en_load, o_frame_done,
                          o_scroll_done, o_max7219_if_data, o_rdata}, 32'h0);
    rst = 1'b0;
    words.delete();
    repeat (20) @(negedge clk);
    check("t6_idle_no_words", words.size(), 0);
    host_rd(8'hFE, rd);
    check("t6_ram_kept", rd, 8'hA0);

    start_scroll(8'h00, 8'd0, 1'b0, 1'b0, 4'h1, 32'd0);
    check("t7_len0_busy", o_busy, 0);
    repeat (20) @(negedge clk);
    check("t7_len0_words", words.size() + sd_cyc.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
